// File: rtl/ex_muldiv_if.sv
// rtl/ex_muldiv_if.sv - Request/result bundle between ID/EX control and the multiply/divide unit
//   master: drives start/op/a/b/flush, observes hi/lo/busy/done
//   slave : the multiply/divide unit
interface ex_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output start, op, a, b, flush,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, a, b, flush,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - Iterative MULTU/DIVU unit with HI/LO registers for the EX stage
//   clk, rst : clock, synchronous active-high reset
//   m (slave): start/op/a/b/flush in; hi/lo architectural registers, busy (stall), done pulse out
//   op[1:0]: 00 MULTU, 01 DIVU, 10 MTHI, 11 MTLO; op[2] selects signed MULT/DIV
//   Optional macro MULDIV_SIGNED_EN builds the signed magnitude/fixup path; otherwise op[2] is ignored.
module ex_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  ex_muldiv_if.slave m
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      count_q;
  logic [2*WIDTH-1:0] acc_q, acc_next;
  logic [WIDTH-1:0]   opnd_q;
  logic               is_div_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;
  logic               accept_md, wr_hi, wr_lo, step, commit;
  logic [WIDTH:0]     mul_sum, div_trial;
  logic [WIDTH-1:0]   a_mag, b_mag, res_hi, res_lo;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // flush outranks start in IDLE and aborts a running op without commit
  always_comb begin
    state_d   = state_q;
    accept_md = 1'b0;
    wr_hi     = 1'b0;
    wr_lo     = 1'b0;
    step      = 1'b0;
    commit    = 1'b0;
    case (state_q)
      IDLE: begin
        if (m.start && !m.flush) begin
          case (m.op[1:0])
            2'b10:   wr_hi = 1'b1;
            2'b11:   wr_lo = 1'b1;
            default: begin
              accept_md = 1'b1;
              state_d   = RUN;
            end
          endcase
        end
      end
      RUN: begin
        if (m.flush) begin
          state_d = IDLE;
        end else begin
          step = 1'b1;
          if (count_q == LAST) begin
            commit  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // acc holds {upper, lower}: multiply keeps {partial product, remaining multiplier bits},
  // divide keeps {partial remainder, dividend bits shifting into quotient bits}.
  // Both leave {hi, lo} in the same halves, so commit needs no per-op muxing.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
    if (is_div_q) begin
      // borrow out of the trial subtract means restore (keep the shifted remainder)
      if (div_trial[WIDTH]) acc_next = {acc_q[2*WIDTH-2:0], 1'b0};
      else                  acc_next = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

`ifdef MULDIV_SIGNED_EN
  logic               sa, sb;
  logic               neg_q_q, neg_r_q, div0_q;
  logic [2*WIDTH-1:0] prod_neg;

  assign sa       = m.op[2] & m.a[WIDTH-1];
  assign sb       = m.op[2] & m.b[WIDTH-1];
  assign a_mag    = sa ? -m.a : m.a;
  assign b_mag    = sb ? -m.b : m.b;
  assign prod_neg = -acc_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      div0_q  <= 1'b0;
    end else if (accept_md) begin
      neg_q_q <= sa ^ sb;
      neg_r_q <= sa;
      div0_q  <= (m.b == '0);
    end
  end

  // divide by zero keeps the all-ones quotient unsigned; the remainder fixup restores a
  always_comb begin
    res_hi = acc_next[2*WIDTH-1:WIDTH];
    res_lo = acc_next[WIDTH-1:0];
    if (is_div_q) begin
      if (neg_r_q)            res_hi = -acc_next[2*WIDTH-1:WIDTH];
      if (neg_q_q && !div0_q) res_lo = -acc_next[WIDTH-1:0];
    end else if (neg_q_q) begin
      res_hi = prod_neg[2*WIDTH-1:WIDTH];
      res_lo = prod_neg[WIDTH-1:0];
    end
  end
`else
  logic unused_op2;

  assign unused_op2 = m.op[2];
  assign a_mag      = m.a;
  assign b_mag      = m.b;
  assign res_hi     = acc_next[2*WIDTH-1:WIDTH];
  assign res_lo     = acc_next[WIDTH-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= commit;
      if (accept_md) begin
        count_q  <= '0;
        is_div_q <= m.op[0];
        acc_q    <= {{WIDTH{1'b0}}, (m.op[0] ? a_mag : b_mag)};
        opnd_q   <= m.op[0] ? b_mag : a_mag;
      end else if (step) begin
        acc_q   <= acc_next;
        count_q <= count_q + 1'b1;
      end
      if (commit) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
      if (wr_hi) hi_q <= m.a;
      if (wr_lo) lo_q <= m.a;
    end
  end

  assign m.hi   = hi_q;
  assign m.lo   = lo_q;
  assign m.busy = (state_q == RUN);
  assign m.done = done_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - Self-checking bench for ex_muldiv with a transaction-level HI/LO model
module tb_ex_muldiv;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_muldiv_if #(.WIDTH(W)) mi ();
  ex_muldiv #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .m(mi));

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  logic [W-1:0]   e_hi = '0, e_lo = '0;
  logic           e_busy = 1'b0, e_done = 1'b0;
  int             left = 0;
  logic [2*W-1:0] e_res = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // {hi, lo} from plain arithmetic
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    bit     sgn;
    longint sa, sb, p, q, r;
    sgn = 1'b0;
`ifdef MULDIV_SIGNED_EN
    sgn = op[2];
`endif
    sa = $signed(a);
    sb = $signed(b);
    if (op[0] == 1'b0) begin
      if (sgn) begin
        p = sa * sb;
        return p;
      end
      return {32'b0, a} * {32'b0, b};
    end
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  always @(posedge clk) begin : model
    if (rst) begin
      e_hi = '0; e_lo = '0; e_busy = 1'b0; e_done = 1'b0; left = 0;
    end else begin
      e_done = 1'b0;
      if (e_busy) begin
        if (mi.flush) e_busy = 1'b0;
        else begin
          left--;
          if (left == 0) begin
            {e_hi, e_lo} = e_res;
            e_done = 1'b1;
            e_busy = 1'b0;
          end
        end
      end else if (mi.start && !mi.flush) begin
        case (mi.op[1:0])
          2'b10:   e_hi = mi.a;
          2'b11:   e_lo = mi.a;
          default: begin
            e_res  = ref_result(mi.op, mi.a, mi.b);
            e_busy = 1'b1;
            left   = W;
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin : compare
    if (chk_en) begin
      chk("cyc_hi", mi.hi, e_hi);
      chk("cyc_lo", mi.lo, e_lo);
      chk("cyc_busy", mi.busy, e_busy);
      chk("cyc_done", mi.done, e_done);
    end
  end

  // called at a negedge; returns at the negedge of the done cycle
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int nb);
    bit ok;
    mi.start = 1'b1; mi.op = op; mi.a = a; mi.b = b;
    @(negedge clk);
    mi.start = 1'b0;
    nb = 0;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (mi.done) begin
        ok = 1'b1;
        break;
      end
      if (mi.busy) nb++;
      @(negedge clk);
    end
    chk("op_timeout", ok, 1'b1);
  endtask

  task automatic pulse(input logic [2:0] op, input logic [31:0] a);
    mi.start = 1'b1; mi.op = op; mi.a = a; mi.b = '0;
    @(negedge clk);
    mi.start = 1'b0;
  endtask

  initial begin
    int  nb;
    bit  seen;
    mi.start = 1'b0; mi.op = '0; mi.a = '0; mi.b = '0; mi.flush = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_hi", mi.hi, 0);
    chk("rst_lo", mi.lo, 0);
    chk("rst_busy", mi.busy, 0);
    chk("rst_done", mi.done, 0);
    rst = 1'b0;
    @(negedge clk);

    chk("ref_mul", ref_result(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
    chk("ref_div", ref_result(3'b001, 100, 7), {32'd2, 32'd14});
    chk("ref_div0", ref_result(3'b001, 5, 0), {32'd5, 32'hFFFF_FFFF});

    pulse(3'b010, 32'h1234_5678);
    chk("mthi", mi.hi, 32'h1234_5678);
    chk("mthi_busy", mi.busy, 0);
    pulse(3'b011, 32'h9ABC_DEF0);
    chk("mtlo", mi.lo, 32'h9ABC_DEF0);
    chk("mtlo_hi", mi.hi, 32'h1234_5678);

    run_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, nb);
    chk("mul_busy_cycles", nb, 32);
    chk("mul_hi", mi.hi, 32'hFFFF_FFFE);
    chk("mul_lo", mi.lo, 32'h0000_0001);
    @(negedge clk);
    chk("mul_done_one", mi.done, 0);

    run_op(3'b001, 100, 7, nb);
    chk("div_busy_cycles", nb, 32);
    chk("div_lo", mi.lo, 14);
    chk("div_hi", mi.hi, 2);
    @(negedge clk);
    run_op(3'b001, 5, 0, nb);
    chk("div0_busy_cycles", nb, 32);
    chk("div0_hi", mi.hi, 5);
    chk("div0_lo", mi.lo, 32'hFFFF_FFFF);
    @(negedge clk);

    // MTHI while busy is ignored
    mi.start = 1'b1; mi.op = 3'b000; mi.a = 6; mi.b = 7;
    @(negedge clk);
    mi.op = 3'b010; mi.a = 32'hDEAD_BEEF;
    @(negedge clk);
    mi.start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (mi.done) seen = 1'b1;
      else @(negedge clk);
    end
    chk("mthi_ign_done", seen, 1);
    chk("mthi_ign_hi", mi.hi, 0);
    chk("mthi_ign_lo", mi.lo, 42);
    @(negedge clk);

    // flush on the 10th busy cycle
    mi.start = 1'b1; mi.op = 3'b000; mi.a = 3; mi.b = 5;
    @(negedge clk);
    mi.start = 1'b0;
    repeat (9) @(negedge clk);
    chk("flush_busy_before", mi.busy, 1);
    mi.flush = 1'b1;
    @(negedge clk);
    mi.flush = 1'b0;
    chk("flush_busy", mi.busy, 0);
    chk("flush_hi", mi.hi, 0);
    chk("flush_lo", mi.lo, 42);
    repeat (40) @(negedge clk);

    // flush and start together: nothing starts
    mi.start = 1'b1; mi.flush = 1'b1; mi.op = 3'b000; mi.a = 9; mi.b = 9;
    @(negedge clk);
    chk("fs_busy", mi.busy, 0);
    mi.op = 3'b010; mi.a = 32'hAAAA_5555;
    @(negedge clk);
    mi.start = 1'b0; mi.flush = 1'b0;
    chk("fs_hi", mi.hi, 0);

    // back-to-back: second start issued in the done cycle
    run_op(3'b000, 3, 5, nb);
    chk("b2b_first_lo", mi.lo, 15);
    run_op(3'b001, 100, 7, nb);
    chk("b2b_busy_cycles", nb, 32);
    chk("b2b_lo", mi.lo, 14);
    @(negedge clk);

    run_op(3'b100, 32'hFFFF_FFFD, 5, nb);
`ifdef MULDIV_SIGNED_EN
    chk("smul_hi", mi.hi, 32'hFFFF_FFFF);
`else
    chk("smul_hi", mi.hi, 32'h0000_0004);
`endif
    chk("smul_lo", mi.lo, 32'hFFFF_FFF1);
    @(negedge clk);
    run_op(3'b101, 32'hFFFF_FFF9, 2, nb);
`ifdef MULDIV_SIGNED_EN
    chk("sdiv_lo", mi.lo, 32'hFFFF_FFFD);
    chk("sdiv_hi", mi.hi, 32'hFFFF_FFFF);
`else
    chk("sdiv_lo", mi.lo, 32'h7FFF_FFFC);
    chk("sdiv_hi", mi.hi, 32'h0000_0001);
`endif
    @(negedge clk);

    // reset in the middle of a MULTU
    mi.start = 1'b1; mi.op = 3'b000; mi.a = 32'h0001_0003; mi.b = 32'h0002_0007;
    @(negedge clk);
    mi.start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_hi", mi.hi, 0);
    chk("mrst_lo", mi.lo, 0);
    chk("mrst_busy", mi.busy, 0);
    chk("mrst_done", mi.done, 0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (mi.done) seen = 1'b1;
    end
    chk("mrst_no_done", seen, 0);

    // random traffic, checked every cycle by the model
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(0, 599) == 0);
      mi.start = ($urandom_range(0, 3) == 0);
      mi.op    = 3'($urandom);
      mi.a     = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      case ($urandom_range(0, 5))
        0:       mi.b = '0;
        1, 2:    mi.b = 32'($urandom_range(1, 20));
        default: mi.b = $urandom;
      endcase
      mi.flush = ($urandom_range(0, 49) == 0);
      @(negedge clk);
    end
    rst = 1'b0; mi.start = 1'b0; mi.flush = 1'b0;
    repeat (40) @(negedge clk);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative multiply/divide unit with HI/LO registers for the EX stage of the pipelined CPU. It takes the register operands and the decoded multiply/divide operation latched in the ID/EX pipeline register and runs MULTU/DIVU, one bit per cycle. It also executes MTHI/MTLO and holds the HI/LO architectural registers. `busy` feeds the hazard unit, which stalls IF/ID/EX while a result is pending.

## Interface
- WIDTH, 32, operand, HI and LO width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  operation valid this cycle (from ID/EX control)
- op  in  3  [1:0]: 00 MULTU, 01 DIVU, 10 MTHI, 11 MTLO; [2]: signed (MULT/DIV), see Configuration
- a  in  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO data)
- b  in  WIDTH  rt operand (multiplier / divisor)
- flush  in  1  abort in-flight operation (jump/branch squash)
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- busy  out  1  multiply/divide in progress; stall request
- done  out  1  one-cycle pulse: HI/LO just committed by MUL/DIV

## Operation
- States: IDLE, RUN.
- IDLE, start=1, op MTHI/MTLO: hi (or lo) <= a at that edge. State stays IDLE. busy and done stay 0.
- IDLE, start=1, op MULTU/DIVU: latch operands and clear the accumulator/partial remainder. Set count=0 and go to RUN.
- RUN, MULTU: shift-add, one multiplier bit per cycle, 2*WIDTH-bit product.
- RUN, DIVU: restoring division, one quotient bit per cycle. Result: lo=quotient, hi=remainder.
- RUN does WIDTH iterations. On the edge of the last iteration it commits hi/lo, pulses done, and returns to IDLE.
- Divide by zero (b=0): no trap. Result hi=a, lo={WIDTH{1}}. Same latency as a normal divide.
- start while busy: ignored, no effect on hi/lo or the running operation. The hazard unit must hold the instruction.
- flush in RUN: return to IDLE at that edge. hi/lo unchanged, no done.
- flush and start in the same IDLE cycle: flush wins, start ignored.
- rst at any time, including mid-RUN: state IDLE, hi=0, lo=0, busy=0, done=0, internal accumulators 0.
- The final result is truncated to exactly WIDTH bits per register. No overflow flag.

## Timing
- Reset values: hi=0, lo=0, busy=0, done=0.
- MTHI/MTLO: value visible on hi/lo in the cycle after the start edge. Latency 1.
- MUL/DIV: start sampled at edge E0.
  - busy=1 from after E0 through edge E0+WIDTH.
  - At edge E0+WIDTH: hi/lo updated, done=1 and busy=0 for that cycle.
  - Next operation accepted at edge E0+WIDTH at the earliest (back-to-back start allowed in the done cycle).
- hi/lo hold previous values throughout RUN. MFHI/MFLO must stall on busy.
- busy and done are registered outputs with no combinational path from inputs.

## Configuration
- Macro MULDIV_SIGNED_EN.
- Defined: op[2]=1 selects signed MULT/DIV.
  - Operands are converted to magnitudes at start. The sign is applied at commit.
  - Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
  - Signed divide by zero gives the same result as unsigned (hi=a, lo=all ones).
  - Latency is unchanged.
- Undefined: op[2] is ignored and all MUL/DIV are unsigned. No sign-fixup logic is built.

## Test plan
- Reset: assert rst mid-RUN of a MULTU -> next cycle hi=0, lo=0, busy=0, done=0; no later done.
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy for 32 cycles, then hi=0xFFFFFFFE, lo=0x00000001, done high exactly one cycle.
- DIVU a=100 b=7 -> lo=14, hi=2. DIVU a=5 b=0 -> hi=5, lo=0xFFFFFFFF. Both after 32 cycles.
- MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 -> hi/lo updated one cycle each, busy never asserted. A MTHI issued during a running MULTU is ignored; the MULTU result is intact.
- MULTU 3*5 with flush on the 10th busy cycle -> busy drops next cycle, hi/lo keep prior values, no done. flush+start in the same cycle -> nothing starts.
- With MULDIV_SIGNED_EN:
  - MULT a=-3 b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Without the macro, the same DIV gives lo=0x7FFFFFFC, hi=0x00000001 (unsigned 0xFFFFFFF9/2).
